input_ctrl: RTL and testbench

Front-end controller for the stopwatch's user inputs. Synchronizes the two mode switches, debounces the pause and reset push-buttons, and runs the run/pause state machine. It outputs clean one-cycle command pulses and level-mode signals to the counter and display datapath. It sits between the board pins and the stopwatch counter, in the master clock domain.

---
 rtl/input_ctrl.sv | 142 ++++++++++++++
 tb/tb_input_ctrl.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/input_ctrl.sv
// input_ctrl: stopwatch front end. Synchronizes the SEL/ADJ switches,
// debounces the pause and clear buttons, and runs the run/pause FSM.

// One button lane: 2-flop synchronizer, stable-count debouncer and
// the delayed stable copy used for rising-edge detection.
module input_ctrl_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic rise
);
    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1, s2;
    logic          stable, stable_d;
    logic [CW-1:0] count;

    // Two-stage synchronizer for the asynchronous pin.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // Accept a new level only after it has differed from stable for
    // DEBOUNCE_CYCLES consecutive samples; any return restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable <= 1'b0;
            count  <= '0;
        end else if (s2 == stable) begin
            count <= '0;
        end else if (count == LAST) begin
            stable <= s2;
            count  <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    // Delayed copy of the accepted level for press detection.
    always_ff @(posedge clk) begin
        if (rst) stable_d <= 1'b0;
        else     stable_d <= stable;
    end

    // Press edge only; releases are deliberately ignored.
    assign rise = stable & ~stable_d;
endmodule

module input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] sw,
    input  logic       btn_pause,
    input  logic       btn_rst,
    output logic       sel,
    output logic       adj,
    output logic       running,
    output logic       pause_pulse,
    output logic       clear_pulse
);
    localparam int NUM_BTN = 2;  // lane 0 = pause, lane 1 = clear

    typedef enum logic {RUN = 1'b0, PAUSED = 1'b1} state_t;

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_rise;
    logic [1:0]         sw_s1, sw_s2;
    state_t             state, state_next;

    assign btn_raw = {btn_rst, btn_pause};

    genvar g;
    generate
        for (g = 0; g < NUM_BTN; g++) begin : g_btn
            input_ctrl_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_db (
                .clk  (clk),
                .rst  (rst),
                .raw  (btn_raw[g]),
                .rise (btn_rise[g])
            );
        end
    endgenerate

    // Switches are level controls: synchronize only, no debounce.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_s1 <= 2'b00;
            sw_s2 <= 2'b00;
        end else begin
            sw_s1 <= sw;
            sw_s2 <= sw_s1;
        end
    end

    assign sel = sw_s2[0];
    assign adj = sw_s2[1];

    // Registered one-cycle command strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            pause_pulse <= 1'b0;
            clear_pulse <= 1'b0;
        end else begin
            pause_pulse <= btn_rise[0];
            clear_pulse <= btn_rise[1];
        end
    end

    // Run/pause state register; comes out of reset running.
    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_next;
    end

    // A pause press toggles the state on the same edge that raises
    // pause_pulse; clear and adj never influence it.
    always_comb begin
        state_next = state;
        if (btn_rise[0]) begin
            case (state)
                RUN:     state_next = PAUSED;
                PAUSED:  state_next = RUN;
                default: state_next = RUN;
            endcase
        end
    end

    assign running = (state == RUN);
endmodule

// File: tb/tb_input_ctrl.sv
// Randomized + directed bench for input_ctrl with a scoreboard. The model
// works on sample histories: a button level is accepted once the last D
// synchronized samples all disagree with the current accepted level.
module tb_input_ctrl;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] sw;
    logic       btn_pause, btn_rst;
    logic       sel, adj, running, pause_pulse, clear_pulse;

    input_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
        .clk         (clk),
        .rst         (rst),
        .sw          (sw),
        .btn_pause   (btn_pause),
        .btn_rst     (btn_rst),
        .sel         (sel),
        .adj         (adj),
        .running     (running),
        .pause_pulse (pause_pulse),
        .clear_pulse (clear_pulse)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic sel;
        logic adj;
        logic running;
        logic pp;
        logic cp;
    } exp_t;

    exp_t       expq[$];
    logic [1:0] hsw[$];   // switch samples (reset seeds zeros)
    logic [1:0] hbt[$];   // button samples {clear, pause}
    logic [1:0] vq[$];    // synchronized views seen by the debouncer
    logic [1:0] st_m;     // model accepted levels
    logic [1:0] rose_m;   // accepted rising at previous edge
    logic       run_m;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         model_pp = 0;
    int         dut_pp   = 0;

    // Reference model: one expected output vector per clock edge.
    always @(posedge clk) begin
        exp_t       e;
        logic [1:0] v;
        logic [1:0] flip;
        if (rst) begin
            hsw = {2'b00, 2'b00};
            hbt = {2'b00, 2'b00};
            vq.delete();
            st_m   = 2'b00;
            rose_m = 2'b00;
            run_m  = 1'b1;
            e = '{sel: 1'b0, adj: 1'b0, running: 1'b1, pp: 1'b0, cp: 1'b0};
        end else begin
            e.sel = hsw[hsw.size()-1][0];
            e.adj = hsw[hsw.size()-1][1];
            v = hbt[hbt.size()-2];
            hsw.push_back(sw);
            hbt.push_back({btn_rst, btn_pause});
            while (hsw.size() > 3) void'(hsw.pop_front());
            while (hbt.size() > 3) void'(hbt.pop_front());
            vq.push_back(v);
            while (vq.size() > D) void'(vq.pop_front());
            e.pp = rose_m[0];
            e.cp = rose_m[1];
            if (rose_m[0]) begin
                run_m = ~run_m;
                model_pp++;
            end
            e.running = run_m;
            for (int b = 0; b < 2; b++) begin
                flip[b] = (vq.size() == D);
                foreach (vq[i]) if (vq[i][b] == st_m[b]) flip[b] = 1'b0;
                if (flip[b]) st_m[b] = ~st_m[b];
                rose_m[b] = flip[b] & st_m[b];
            end
        end
        expq.push_back(e);
    end

    // Monitor: compare the DUT against the oldest pending expectation.
    always @(negedge clk) begin
        exp_t e;
        exp_t a;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            a = '{sel: sel, adj: adj, running: running, pp: pause_pulse, cp: clear_pulse};
            if (pause_pulse) dut_pp++;
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL outputs @%0t: got sel/adj/run/pp/cp=%b expected %b", $time, a, e);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; sw = 2'b00; btn_pause = 1'b0; btn_rst = 1'b0;
        cyc(2);
        rst = 1'b0;
        cyc(8);
        // Clean pause presses: pause then resume.
        btn_pause = 1'b1; cyc(20); btn_pause = 1'b0; cyc(20);
        btn_pause = 1'b1; cyc(20); btn_pause = 1'b0; cyc(20);
        // Bounce, then a steady hold.
        for (int i = 0; i < 8; i++) begin btn_pause = ~btn_pause; cyc(1); end
        btn_pause = 1'b1; cyc(12); btn_pause = 1'b0; cyc(12);
        // Clear while paused, then a short clear glitch.
        btn_rst = 1'b1; cyc(10); btn_rst = 1'b0; cyc(10);
        btn_rst = 1'b1; cyc(3);  btn_rst = 1'b0; cyc(10);
        // Simultaneous presses.
        btn_pause = 1'b1; btn_rst = 1'b1; cyc(10);
        btn_pause = 1'b0; btn_rst = 1'b0; cyc(10);
        // Reset during a held button's count.
        btn_pause = 1'b1; cyc(3); rst = 1'b1; cyc(2); rst = 1'b0; cyc(12);
        btn_pause = 1'b0; cyc(10);
        // Switch change while a button is held.
        btn_rst = 1'b1; cyc(2); sw = 2'b10; cyc(4); sw = 2'b01; cyc(8);
        btn_rst = 1'b0; cyc(10);
        // Random phase: mixed hold lengths, switch flips, rare resets.
        for (int i = 0; i < 400; i++) begin
            btn_pause = 1'($urandom_range(0, 1));
            btn_rst   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) sw = 2'($urandom);
            rst = ($urandom_range(0, 40) == 0);
            cyc($urandom_range(1, 2 * D + 2));
        end
        rst = 1'b0; btn_pause = 1'b0; btn_rst = 1'b0;
        cyc(12);
        n_checks++;
        if (dut_pp != model_pp || model_pp == 0) begin
            n_fail++;
            $display("FAIL pause_pulse_count: got %0d expected %0d", dut_pp, model_pp);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
